// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding and source ids shared by the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    STOPPED = 2'd2
  } state_t;
  localparam logic SRC_IF = 1'b0;
  localparam logic SRC_LS = 1'b1;
endpackage

// File: rtl/mem_arb_src_fifo.sv
// mem_arb_src_fifo: 1-bit source-id FIFO tracking which requester owns each in-flight access
module mem_arb_src_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          din,
  output logic          head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0] mem;
  logic [AW-1:0] wptr, rptr;
  logic do_pop, do_push;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head = mem[rptr];
  // storage and pointers; a push into a full FIFO is legal when the head leaves in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wptr] <= din;
      wptr <= wptr + AW'(do_push);
      rptr <= rptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store with in-order routing and drain/stop
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_OUT = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              stop_req,
  output logic              quiesced,
  output logic              proto_err
);
  localparam int CW = $clog2(MAX_OUT) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  state_t state, state_nx;
  logic [CW-1:0] outstanding;
  logic [SW-1:0] streak;
  logic full, empty, head, pop, issue, sel_if, gnt;
  assign pop = mem_rvalid & ~empty;
  assign issue = rst_n && state == RUN && !stop_req && (!full || pop);
  assign sel_if = if_req & (~ls_req | streak == SW'(STARVE_LIMIT));
  assign mem_req = issue & (if_req | ls_req);
  assign gnt = mem_req & mem_gnt;
  assign if_gnt = gnt & sel_if;
  assign ls_gnt = gnt & ~sel_if;
  assign mem_we = mem_req & ~sel_if & ls_we;
  assign mem_be = !mem_req ? '0 : sel_if ? '1 : ls_be;
  assign mem_addr = !mem_req ? '0 : sel_if ? if_addr : ls_addr;
  assign mem_wdata = mem_req & ~sel_if ? ls_wdata : '0;
  assign if_rvalid = pop & head == SRC_IF;
  assign ls_rvalid = pop & head == SRC_LS;
  assign if_rdata = rst_n ? mem_rdata : '0;
  assign ls_rdata = rst_n ? mem_rdata : '0;
  assign quiesced = state == STOPPED;
  mem_arb_src_fifo #(.DEPTH(MAX_OUT)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(gnt),
    .pop(pop),
    .din(sel_if ? SRC_IF : SRC_LS),
    .head(head),
    .full(full),
    .empty(empty),
    .count(outstanding)
  );
  // drain sequencing: stop leads to DRAIN, and STOPPED once nothing is in flight
  always_comb begin
    state_nx = state;
    state_nx = !stop_req ? RUN : state == RUN ? DRAIN : (state == STOPPED || outstanding == '0) ? STOPPED : DRAIN;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else state <= state_nx;
  end
  // fairness streak and sticky protocol error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
      proto_err <= 1'b0;
    end else begin
      streak <= (if_gnt || !if_req) ? '0 : (ls_gnt && streak != SW'(STARVE_LIMIT)) ? streak + SW'(1) : streak;
      proto_err <= proto_err | (mem_rvalid & empty);
    end
  end
endmodule
